// File: rtl/aes_result_display.sv
// aes_result_display: registers the AES export word, decodes it onto eight
// active-low seven-segment digits, counts displayed updates on ledg, and
// offers debounced freeze / count-clear push-buttons.
module aes_result_display #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          BLANK_LEADING   = 1'b1
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [31:0] data_in,
  input  logic [1:0]  key_n,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic [6:0]  hex6,
  output logic [6:0]  hex7,
  output logic [7:0]  ledg,
  output logic        frozen
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [6:0] SEG_ZERO  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  logic [1:0]    key_sync1;
  logic [1:0]    key_sync2;
  logic [1:0]    key_lvl;
  logic [1:0]    press;
  logic [CW-1:0] db_cnt [2];

  logic [31:0]   disp_reg;
  logic          change;
  logic [6:0]    hex_q    [8];
  logic [6:0]    hex_next [8];

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Two-flop synchronizer for the raw buttons; idles at released (1).
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      key_sync1 <= '1;
      key_sync2 <= '1;
    end else begin
      key_sync1 <= key_n;
      key_sync2 <= key_sync1;
    end
  end

  // Debounce: the counter runs while the synchronized level disagrees with
  // the accepted level and restarts on any agreement, so only a level held
  // for DEBOUNCE_CYCLES consecutive cycles is accepted. A press pulse is
  // emitted only on acceptance of a 1->0 transition.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      key_lvl <= '1;
      press   <= '0;
      for (int unsigned i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      press <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        if (key_sync2[i] != key_lvl[i]) begin
          if (db_cnt[i] == CNT_MAX) begin
            key_lvl[i] <= key_sync2[i];
            db_cnt[i]  <= '0;
            press[i]   <= ~key_sync2[i];
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // A displayed update is a new word arriving while not frozen.
  always_comb begin
    change = (data_in != disp_reg) && !frozen;
  end

  // Capture register, freeze toggle and update counter (clear wins).
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      disp_reg <= '0;
      frozen   <= 1'b0;
      ledg     <= '0;
    end else begin
      if (!frozen) disp_reg <= data_in;
      if (press[0]) frozen <= ~frozen;
      if (press[1])    ledg <= '0;
      else if (change) ledg <= ledg + 8'd1;
    end
  end

  // Decode each nibble, blanking digits above the top nonzero nibble.
  always_comb begin
    logic       seen;
    logic [3:0] nib;
    int unsigned k;
    seen = 1'b0;
    nib  = '0;
    k    = 0;
    for (int unsigned j = 0; j < 8; j++) hex_next[j] = SEG_BLANK;
    for (int unsigned j = 0; j < 8; j++) begin
      k    = 7 - j;
      nib  = disp_reg[4*k +: 4];
      seen = seen | (nib != 4'h0);
      if (BLANK_LEADING && (k != 0) && !seen) hex_next[k] = SEG_BLANK;
      else                                    hex_next[k] = seg_decode(nib);
    end
  end

  // Registered segment outputs; reset image matches a displayed zero.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      hex_q[0] <= SEG_ZERO;
      for (int unsigned i = 1; i < 8; i++) hex_q[i] <= BLANK_LEADING ? SEG_BLANK : SEG_ZERO;
    end else begin
      for (int unsigned i = 0; i < 8; i++) hex_q[i] <= hex_next[i];
    end
  end

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];
  assign hex6 = hex_q[6];
  assign hex7 = hex_q[7];

endmodule
